zbt_point_writer: RTL and testbench

ZBT_POINT_WRITER -- requirements
Module: zbt_point_writer

---
 rtl/zbt_point_writer.sv | 177 +++++++++++++++++
 tb/tb_zbt_point_writer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zbt_point_writer.sv
// ---------------------------------------------------------------------------
// zbt_point_writer
//
// Purpose:
//   Writes a short run of NUM_POINTS test points into a ZBT SRAM through a
//   valid/ready write port. Point i sits at address BASE_ADDR+i. Its word
//   packs {zero pad, x, y, color}, with
//   x = X0 + i*STEP, y = Y0 + i*STEP (both modulo 2^COORD_W) and
//   color = COLOR0 >> i.
//
// Ports:
//   clk       - single clock, all state on its rising edge
//   reset_n   - asynchronous active-low reset
//   start     - a high level sampled in IDLE begins a run
//   wr_ready  - ZBT write port accepts the current word
//   wr_valid  - wr_addr / wr_data are valid
//   wr_addr   - write address (ADDR_W bits)
//   wr_data   - 36-bit write word
//   busy      - high while a run is in progress
//   done      - one-cycle pulse at the end of a run
//
// Configuration:
//   ZBT_POINT_CLEAR_EN - when defined, each run first writes zero words to
//                        the NUM_POINTS target addresses (CLEAR state), then
//                        writes the points.
// ---------------------------------------------------------------------------
module zbt_point_writer #(
   parameter int                 NUM_POINTS = 4,
   parameter int                 COORD_W    = 10,
   parameter int                 COLOR_W    = 10,
   parameter int                 ADDR_W     = 19,
   parameter int                 BASE_ADDR  = 0,
   parameter int                 X0         = 300,
   parameter int                 Y0         = 300,
   parameter int                 STEP       = 100,
   parameter logic [COLOR_W-1:0] COLOR0     = COLOR_W'(10'b1111111100)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              wr_ready,
   output logic              wr_valid,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [35:0]       wr_data,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(NUM_POINTS + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
`ifdef ZBT_POINT_CLEAR_EN
   localparam logic [1:0] S_CLEAR = 2'd1;
`endif
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_POINTS - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             xfer;

   // A word moves only when both sides agree. The next index is computed
   // once so that the output registers can be loaded with the next point
   // in the same cycle a transfer happens. This keeps the stream free of
   // bubbles while wr_ready stays high.
   assign xfer    = wr_valid & wr_ready;
   assign cnt_nxt = cnt + CNT_W'(1);

   // Address of point idx. The sum is truncated to ADDR_W, so it wraps
   // naturally modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] point_addr(input logic [CNT_W-1:0] idx);
      return ADDR_W'(BASE_ADDR) + ADDR_W'(idx);
   endfunction

   // Data word of point idx. Coordinates are computed in integer arithmetic
   // and truncated to COORD_W, which gives the modulo wrap. Shifting the
   // color right by idx gives zero once idx reaches COLOR_W.
   function automatic logic [35:0] point_word(input logic [CNT_W-1:0] idx);
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [COLOR_W-1:0] c;
      x = COORD_W'(X0 + int'(idx) * STEP);
      y = COORD_W'(Y0 + int'(idx) * STEP);
      c = COLOR0 >> idx;
      return 36'({x, y, c});
   endfunction

   // Main sequencer. All outputs are registered.
   // - wr_addr and wr_data change only when a new word is presented. They
   //   therefore stay stable across a stall and keep their last value in
   //   IDLE.
   // - busy is set when a run leaves IDLE and cleared on the return to IDLE.
   // - done is high only during the single DONE cycle.
   // - start is looked at only in IDLE, so a start seen mid-run is ignored.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  cnt      <= '0;
                  busy     <= 1'b1;
                  wr_valid <= 1'b1;
                  wr_addr  <= point_addr(CNT_ZERO);
`ifdef ZBT_POINT_CLEAR_EN
                  state    <= S_CLEAR;
                  wr_data  <= '0;
`else
                  state    <= S_WRITE;
                  wr_data  <= point_word(CNT_ZERO);
`endif
               end
            end

`ifdef ZBT_POINT_CLEAR_EN
            // Zero-fill pass over the same addresses. After the last clear
            // word, point 0 is presented right away, so no bubble appears
            // between the two passes.
            S_CLEAR: begin
               if (xfer) begin
                  if (cnt == CNT_LAST) begin
                     state   <= S_WRITE;
                     cnt     <= '0;
                     wr_addr <= point_addr(CNT_ZERO);
                     wr_data <= point_word(CNT_ZERO);
                  end else begin
                     cnt     <= cnt_nxt;
                     wr_addr <= point_addr(cnt_nxt);
                     wr_data <= '0;
                  end
               end
            end
`endif

            S_WRITE: begin
               if (xfer) begin
                  cnt <= cnt_nxt;
                  if (cnt == CNT_LAST) begin
                     state    <= S_DONE;
                     wr_valid <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     wr_addr  <= point_addr(cnt_nxt);
                     wr_data  <= point_word(cnt_nxt);
                  end
               end
            end

            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end

            default: begin
               state    <= S_IDLE;
               wr_valid <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zbt_point_writer.sv
// ---------------------------------------------------------------------------
// tb_zbt_point_writer
//
// Directed bench for zbt_point_writer with default parameters. A second
// instance with X0=1000 shares every input, and its stream shows the
// coordinate wrap. When ZBT_POINT_CLEAR_EN is defined, each run is expected
// to begin with four zero words.
// ---------------------------------------------------------------------------
module tb_zbt_point_writer;

`ifdef ZBT_POINT_CLEAR_EN
   localparam int NPRE = 4;
`else
   localparam int NPRE = 0;
`endif
   localparam int NEXP = NPRE + 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        wr_ready;
   logic        wr_valid;
   logic [18:0] wr_addr;
   logic [35:0] wr_data;
   logic        busy;
   logic        done;
   logic        wr_valid2;
   logic [18:0] wr_addr2;
   logic [35:0] wr_data2;
   logic        busy2;
   logic        done2;

   int errors = 0;
   int checks = 0;

   logic [18:0] log_addr[$];
   logic [35:0] log_data[$];
   logic [35:0] log_data2[$];
   int          done_cnt = 0;

   zbt_point_writer dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .wr_ready (wr_ready),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done)
   );

   zbt_point_writer #(.X0(1000)) dut_wrap (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .wr_ready (wr_ready),
      .wr_valid (wr_valid2),
      .wr_addr  (wr_addr2),
      .wr_data  (wr_data2),
      .busy     (busy2),
      .done     (done2)
   );

   always #5 clk = ~clk;

   // Transfer and done monitor. It samples on the falling edge, where the
   // values that the next rising edge will act on are stable.
   always @(negedge clk) begin
      if (wr_valid && wr_ready) begin
         log_addr.push_back(wr_addr);
         log_data.push_back(wr_data);
      end
      if (wr_valid2 && wr_ready) log_data2.push_back(wr_data2);
      if (done) done_cnt++;
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Hand-computed point words: {pad, x, y, color}
   function automatic logic [35:0] pointWord(input int i);
      case (i)
         0:       return {6'd0, 10'd300, 10'd300, 10'h3FC};
         1:       return {6'd0, 10'd400, 10'd400, 10'h1FE};
         2:       return {6'd0, 10'd500, 10'd500, 10'h0FF};
         default: return {6'd0, 10'd600, 10'd600, 10'h07F};
      endcase
   endfunction

   function automatic logic [35:0] expWord(input int n);
      return (n < NPRE) ? 36'd0 : pointWord(n - NPRE);
   endfunction

   function automatic logic [18:0] expAddr(input int n);
      return (n < NPRE) ? 19'(n) : 19'(n - NPRE);
   endfunction

   // Pulse start for one cycle, then check that the first word is presented
   // on the very next cycle.
   task automatic applyStimulus(input string tag);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      checkOutput({tag, "_first_valid"}, 64'(wr_valid), 64'd1);
      checkOutput({tag, "_first_addr"}, 64'(wr_addr), 64'd0);
      checkOutput({tag, "_first_data"}, 64'(wr_data), 64'(expWord(0)));
   endtask

   // Bounded wait for the done pulse, then check the busy/done fall.
   task automatic waitDone(input string tag);
      bit seen = 0;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk); #1;
         if (done) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         checkOutput({tag, "_done_timeout"}, 64'd0, 64'd1);
      end else begin
         checkOutput({tag, "_busy_in_done"}, 64'(busy), 64'd1);
         checkOutput({tag, "_valid_in_done"}, 64'(wr_valid), 64'd0);
         @(posedge clk); #1;
         checkOutput({tag, "_done_width"}, 64'(done), 64'd0);
         checkOutput({tag, "_busy_fall"}, 64'(busy), 64'd0);
      end
   endtask

   // Compare the words logged since index base against the expected stream.
   task automatic checkRun(input string tag, input int base);
      int n;
      n = log_addr.size() - base;
      checkOutput({tag, "_count"}, 64'(n), 64'(NEXP));
      for (int i = 0; i < NEXP; i++) begin
         if (base + i < log_addr.size()) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), 64'(log_addr[base + i]), 64'(expAddr(i)));
            checkOutput($sformatf("%s_data%0d", tag, i), 64'(log_data[base + i]), 64'(expWord(i)));
         end
      end
   endtask

   initial begin
      int          base;
      int          base2;
      int          db;
      int          snap;
      bit          found;
      logic [35:0] w2;

      reset_n  = 1'b0;
      start    = 1'b0;
      wr_ready = 1'b1;
      #12;
      checkOutput("rst_valid", 64'(wr_valid), 64'd0);
      checkOutput("rst_addr", 64'(wr_addr), 64'd0);
      checkOutput("rst_data", 64'(wr_data), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("idle_no_write", 64'(log_addr.size()), 64'd0);
      checkOutput("idle_busy", 64'(busy), 64'd0);

      // Basic run, with wr_ready held high
      base  = log_addr.size();
      base2 = log_data2.size();
      db    = done_cnt;
      applyStimulus("t1");
      waitDone("t1");
      checkRun("t1", base);
      checkOutput("t1_done_pulses", 64'(done_cnt - db), 64'd1);
      checkOutput("t1_idle_hold_addr", 64'(wr_addr), 64'd3);
      checkOutput("t1_idle_hold_data", 64'(wr_data), 64'(pointWord(3)));
      if (log_data2.size() > base2 + NPRE + 1) begin
         w2 = log_data2[base2 + NPRE + 1];
         checkOutput("wrap_x", 64'(w2[29:20]), 64'd76);
         checkOutput("wrap_y", 64'(w2[19:10]), 64'd400);
      end else begin
         checkOutput("wrap_count", 64'(log_data2.size() - base2), 64'(NEXP));
      end

      // Three-cycle stall while point 1 is presented
      base  = log_addr.size();
      found = 0;
      applyStimulus("t2");
      for (int c = 0; c < 30; c++) begin
         if (wr_valid && wr_data == pointWord(1)) begin
            found = 1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!found) begin
         checkOutput("t2_point1_timeout", 64'd0, 64'd1);
      end else begin
         wr_ready = 1'b0;
         for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checkOutput("t2_hold_valid", 64'(wr_valid), 64'd1);
            checkOutput("t2_hold_addr", 64'(wr_addr), 64'd1);
            checkOutput("t2_hold_data", 64'(wr_data), 64'(pointWord(1)));
         end
         wr_ready = 1'b1;
      end
      waitDone("t2");
      checkRun("t2", base);

      // A start seen while busy is ignored
      base = log_addr.size();
      db   = done_cnt;
      applyStimulus("t3");
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      waitDone("t3");
      repeat (6) @(posedge clk);
      #1;
      checkRun("t3", base);
      checkOutput("t3_done_pulses", 64'(done_cnt - db), 64'd1);
      checkOutput("t3_busy_after", 64'(busy), 64'd0);

      // Reset in the middle of a run
      base  = log_addr.size();
      found = 0;
      applyStimulus("t4");
      for (int c = 0; c < 20; c++) begin
         if (log_addr.size() - base >= 2) begin
            found = 1;
            break;
         end
         @(posedge clk); #1;
      end
      checkOutput("t4_two_xfers", 64'(found), 64'd1);
      @(posedge clk); #2 reset_n = 1'b0;
      #1;
      checkOutput("t4_rst_valid", 64'(wr_valid), 64'd0);
      checkOutput("t4_rst_addr", 64'(wr_addr), 64'd0);
      checkOutput("t4_rst_data", 64'(wr_data), 64'd0);
      checkOutput("t4_rst_busy", 64'(busy), 64'd0);
      checkOutput("t4_rst_done", 64'(done), 64'd0);
      snap = log_addr.size();
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("t4_no_write_after_rst", 64'(log_addr.size() - snap), 64'd0);
      base = log_addr.size();
      db   = done_cnt;
      applyStimulus("t4r");
      waitDone("t4r");
      checkRun("t4r", base);
      checkOutput("t4r_done_pulses", 64'(done_cnt - db), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
